// File: rtl/axi_burst_rd_engine_if.sv
// AXI read-channel bundle (AR + R) between the burst read engine and the
// controller's AXI read port.
interface axi_burst_rd_engine_if #(
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32
);
   logic                  arvalid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic                  arready;
   logic                  rvalid;
   logic                  rlast;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rready;

   modport master (
      output arvalid, araddr, arlen, rready,
      input  arready, rvalid, rlast, rdata
   );

   modport slave (
      input  arvalid, araddr, arlen, rready,
      output arready, rvalid, rlast, rdata
   );
endinterface

// File: rtl/axi_burst_rd_engine.sv
// AXI burst read engine: splits one request into AXI bursts of at most
// RBURST_LEN beats that never cross a 2^COL_BITS-word DRAM row, returns the
// data on a registered stream and flags RLAST protocol violations.
// Optional macro RD_CHECK_EN adds an incrementing-pattern data checker
// driving rd_error; without it rd_error is tied low.
//
// state  | meaning
// S_IDLE | waiting for rd_trig, rd_ready high
// S_AR   | address phase, arvalid held with stable addr/len
// S_R    | data phase, rready high, counting beats of the burst
// S_DONE | rd_done pulse, back to idle next cycle
module axi_burst_rd_engine #(
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32,
   parameter int COL_BITS   = 10,
   parameter int RBURST_LEN = 8,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_trig,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [LEN_WIDTH-1:0]  rd_len,
   output logic                  rd_ready,
   output logic                  rd_done,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_en,
   output logic                  rd_error,
   output logic                  proto_err,
   axi_burst_rd_engine_if.master axi
);

   typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [LEN_WIDTH-1:0]  remain;
   logic [7:0]            arlen_q;
   logic [7:0]            bcnt;
   logic                  arvalid_q;
   logic                  rready_q;

   logic [8:0]            beats;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [LEN_WIDTH-1:0]  next_remain;
   logic [8:0]            first_beats;
   logic [8:0]            next_beats;
   logic                  beat_fire;

   // Burst size: limited by the burst cap, the beats still owed and the room
   // left in the current DRAM row.
   function automatic logic [8:0] calc_beats(input logic [COL_BITS-1:0] col,
                                             input logic [LEN_WIDTH-1:0] rem);
      logic [31:0] room;
      logic [31:0] lim;
      room = (32'd1 << COL_BITS) - 32'(col);
      lim  = 32'(RBURST_LEN);
      if (32'(rem) < lim) lim = 32'(rem);
      if (room < lim)     lim = room;
      return 9'(lim);
   endfunction

   assign beats       = {1'b0, arlen_q} + 9'd1;
   assign next_addr   = cur_addr + ADDR_WIDTH'(beats);
   assign next_remain = remain - LEN_WIDTH'(beats);
   assign first_beats = calc_beats(rd_addr[COL_BITS-1:0], rd_len);
   assign next_beats  = calc_beats(next_addr[COL_BITS-1:0], next_remain);
   assign beat_fire   = (state == S_R) && axi.rvalid && rready_q;

   assign axi.arvalid = arvalid_q;
   assign axi.araddr  = cur_addr;
   assign axi.arlen   = arlen_q;
   assign axi.rready  = rready_q;

   // Request sequencing FSM with registered handshake and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cur_addr   <= '0;
         remain     <= '0;
         arlen_q    <= '0;
         bcnt       <= '0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         rd_ready   <= 1'b1;
         rd_done    <= 1'b0;
         rd_data    <= '0;
         rd_data_en <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         rd_data_en <= 1'b0;
         rd_done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rd_trig) begin
                  rd_ready <= 1'b0;
                  if (rd_len != '0) begin
                     cur_addr  <= rd_addr;
                     remain    <= rd_len;
                     arlen_q   <= 8'(first_beats - 9'd1);
                     arvalid_q <= 1'b1;
                     state     <= S_AR;
                  end else begin
                     rd_done <= 1'b1;
                     state   <= S_DONE;
                  end
               end
            end
            S_AR: begin
               if (axi.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  bcnt      <= arlen_q;
                  state     <= S_R;
               end
            end
            S_R: begin
               if (beat_fire) begin
                  rd_data    <= axi.rdata;
                  rd_data_en <= 1'b1;
                  bcnt       <= bcnt - 8'd1;
                  if ((bcnt == 8'd0) != axi.rlast) proto_err <= 1'b1;
                  // The beat count, not rlast, decides where a burst ends.
                  if (bcnt == 8'd0) begin
                     cur_addr <= next_addr;
                     remain   <= next_remain;
                     rready_q <= 1'b0;
                     if (next_remain != '0) begin
                        arlen_q   <= 8'(next_beats - 9'd1);
                        arvalid_q <= 1'b1;
                        state     <= S_AR;
                     end else begin
                        rd_done <= 1'b1;
                        state   <= S_DONE;
                     end
                  end
               end
            end
            S_DONE: begin
               rd_ready <= 1'b1;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef RD_CHECK_EN
   logic [ADDR_WIDTH-1:0] base;
   logic [LEN_WIDTH-1:0]  beat_idx;
   logic [DATA_WIDTH-1:0] exp_data;

   // Incrementing-pattern checker: expected word travels one stage alongside
   // rd_data, so a bad beat raises rd_error two cycles after acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base     <= '0;
         beat_idx <= '0;
         exp_data <= '0;
         rd_error <= 1'b0;
      end else begin
         if (state == S_IDLE && rd_trig && rd_len != '0) begin
            base     <= rd_addr;
            beat_idx <= '0;
         end else if (beat_fire) begin
            beat_idx <= beat_idx + 1'b1;
            exp_data <= DATA_WIDTH'(base + ADDR_WIDTH'(beat_idx));
         end
         if (rd_data_en && rd_data != exp_data) rd_error <= 1'b1;
      end
   end
`else
   assign rd_error = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_rd_engine.sv
// Randomized bench for axi_burst_rd_engine: a random-latency AXI slave plus a
// reference model that plans bursts arithmetically from (addr, len).
module tb_axi_burst_rd_engine;
   localparam int AW = 26;
   localparam int DW = 32;
   localparam int CB = 10;
   localparam int RB = 8;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          rd_trig;
   logic [AW-1:0] rd_addr;
   logic [LW-1:0] rd_len;
   logic          rd_ready, rd_done, rd_data_en, rd_error, proto_err;
   logic [DW-1:0] rd_data;

   axi_burst_rd_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   axi_burst_rd_engine #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COL_BITS(CB),
      .RBURST_LEN(RB), .LEN_WIDTH(LW)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_trig(rd_trig), .rd_addr(rd_addr), .rd_len(rd_len),
      .rd_ready(rd_ready), .rd_done(rd_done),
      .rd_data(rd_data), .rd_data_en(rd_data_en),
      .rd_error(rd_error), .proto_err(proto_err),
      .axi(axi)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [7:0]    l;
   } ar_t;

   int total = 0;
   int bad   = 0;

   ar_t           exp_ar[$];
   logic [DW-1:0] exp_dat[$];
   int            pend, pi, gbeat, corrupt_idx, badlast_idx;
   logic [AW-1:0] paddr;
   bit            m_proto, m_rderr, en_due, nb_check;
   int            proto_cd, rderr_cd, beats_rx, done_cnt;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Expected AR sequence from the request alone.
   function automatic void plan(input int unsigned a0, input int len);
      int unsigned a;
      int rem, room, b;
      ar_t e;
      a = a0;
      rem = len;
      while (rem > 0) begin
         room = (1 << CB) - int'(a % (1 << CB));
         b = RB;
         if (rem < b) b = rem;
         if (room < b) b = room;
         e.a = AW'(a);
         e.l = 8'(b - 1);
         exp_ar.push_back(e);
         a = (a + unsigned'(b)) % (1 << AW);
         rem -= b;
      end
   endfunction

   task automatic clear_model();
      exp_ar.delete();
      exp_dat.delete();
      pend = 0; pi = 0; gbeat = 0;
      m_proto = 0; m_rderr = 0; proto_cd = 0; rderr_cd = 0;
      en_due = 0; nb_check = 0;
   endtask

   // One cycle: check outputs at negedge, then act as the AXI slave.
   task automatic step();
      logic [DW-1:0] d;
      logic          last;
      ar_t           e;
      @(negedge clk);
      if (proto_cd > 0) begin proto_cd--; if (proto_cd == 0) m_proto = 1; end
      if (rderr_cd > 0) begin rderr_cd--; if (rderr_cd == 0) m_rderr = 1; end
      check_eq("proto_err", proto_err, m_proto);
      check_eq("rd_error", rd_error, m_rderr);
      check_eq("data_en", rd_data_en, en_due);
      if (rd_data_en && exp_dat.size() > 0) begin
         check_eq("rd_data", rd_data, exp_dat.pop_front());
         beats_rx++;
      end
      if (nb_check) check_eq("next_ar", axi.arvalid, 1'b1);
      nb_check = 0;
      en_due = 0;
      if (rd_done) done_cnt++;

      axi.arready = 1'b0;
      if (axi.arvalid && pend == 0 && $urandom_range(0, 2) != 0) begin
         axi.arready = 1'b1;
         check_eq("ar_expected", exp_ar.size() > 0, 1'b1);
         if (exp_ar.size() > 0) begin
            e = exp_ar.pop_front();
            check_eq("araddr", axi.araddr, e.a);
            check_eq("arlen", axi.arlen, e.l);
         end
         pend  = int'(axi.arlen) + 1;
         paddr = axi.araddr;
         pi    = 0;
      end

      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      axi.rdata  = '0;
      if (pend > 0 && axi.rready && $urandom_range(0, 3) != 0) begin
         d    = DW'(paddr + AW'(pi));
         last = (pi == pend - 1);
         if (gbeat == corrupt_idx) begin
            d = d + 2;
`ifdef RD_CHECK_EN
            rderr_cd = 2;
`endif
         end
         if (gbeat == badlast_idx) begin
            last = !last;
            proto_cd = 1;
         end
         axi.rvalid = 1'b1;
         axi.rlast  = last;
         axi.rdata  = d;
         exp_dat.push_back(d);
         en_due = 1;
         pi++;
         gbeat++;
         if (pi == pend) begin
            pend = 0;
            if (exp_ar.size() > 0) nb_check = 1;
         end
      end

      rd_trig = !rd_ready && ($urandom_range(0, 3) == 0);
      rd_addr = AW'($urandom);
      rd_len  = LW'($urandom_range(0, 50));
   endtask

   task automatic launch(input logic [AW-1:0] addr, input int len, input int cor, input int bl);
      exp_ar.delete();
      exp_dat.delete();
      plan(32'(addr), len);
      gbeat = 0; corrupt_idx = cor; badlast_idx = bl;
      beats_rx = 0; done_cnt = 0; pend = 0;
      @(negedge clk);
      check_eq("ready_before", rd_ready, 1'b1);
      rd_trig = 1'b1;
      rd_addr = addr;
      rd_len  = LW'(len);
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
   endtask

   task automatic run_req(input logic [AW-1:0] addr, input int len, input int cor, input int bl);
      int cyc;
      launch(addr, len, cor, bl);
      step();
      if (len == 0) begin
         check_eq("zero_done", rd_done, 1'b1);
         check_eq("zero_no_ar", axi.arvalid, 1'b0);
         step();
         check_eq("zero_ready", rd_ready, 1'b1);
         check_eq("zero_no_ar2", axi.arvalid, 1'b0);
         check_eq("zero_done_pulse", rd_done, 1'b0);
         return;
      end
      check_eq("ar_latency", axi.arvalid, 1'b1);
      check_eq("busy_ready", rd_ready, 1'b0);
      cyc = 0;
      while (done_cnt == 0 && cyc < 3000) begin
         step();
         cyc++;
      end
      check_eq("done_seen", done_cnt, 1);
      check_eq("done_with_last", rd_data_en, 1'b1);
      check_eq("beat_count", beats_rx, len);
      check_eq("ar_left", exp_ar.size(), 0);
      step();
      check_eq("ready_after", rd_ready, 1'b1);
      check_eq("done_pulse", rd_done, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, rd_ready, 1'b1);
      check_eq({tag, "_done"}, rd_done, 1'b0);
      check_eq({tag, "_data"}, rd_data, '0);
      check_eq({tag, "_en"}, rd_data_en, 1'b0);
      check_eq({tag, "_rderr"}, rd_error, 1'b0);
      check_eq({tag, "_proto"}, proto_err, 1'b0);
      check_eq({tag, "_arvalid"}, axi.arvalid, 1'b0);
      check_eq({tag, "_araddr"}, axi.araddr, '0);
      check_eq({tag, "_arlen"}, axi.arlen, '0);
      check_eq({tag, "_rready"}, axi.rready, 1'b0);
   endtask

   initial begin
      int cyc;
      logic [AW-1:0] a;
      rst = 1'b1;
      rd_trig = 1'b0; rd_addr = '0; rd_len = '0;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = '0;
      clear_model();
      corrupt_idx = -1; badlast_idx = -1;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b0;

      run_req(AW'(0), 8, -1, -1);
      run_req(AW'(0), 20, -1, -1);
      run_req(AW'(1020), 8, -1, -1);
      run_req(AW'(0), 0, -1, -1);
      run_req(AW'((1 << AW) - 3), 10, -1, -1);

      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 0) a = AW'($urandom);
         else a = AW'((($urandom % 64) << CB) + (1024 - $urandom_range(1, 12)));
         run_req(a, $urandom_range(0, 40), -1, -1);
      end

      run_req(AW'(0), 8, 3, -1);
      run_req(AW'(0), 8, -1, 5);
      run_req(AW'(64), 12, -1, -1);

      // Asynchronous reset in the middle of a data phase.
      launch(AW'(256), 20, -1, -1);
      cyc = 0;
      while (gbeat < 5 && cyc < 500) begin
         step();
         cyc++;
      end
      check_eq("mid_r_reached", gbeat >= 5, 1'b1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      rd_trig = 1'b0;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
      #1;
      check_reset_outputs("async");
      repeat (2) @(negedge clk);
      check_reset_outputs("held");
      clear_model();
      rst = 1'b0;
      run_req(AW'(1016), 17, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
